fifo_write_arbiter: RTL and testbench

- Round-robin arbiter that shares the single write port of one parallel-write FIFO among NUM_REQ producers (e.g. several IFmap/filter loaders feeding one buffer).
- Grants one producer at a time for a fixed burst of BURST_LEN beats, so one producer's words stay contiguous in the FIFO.
- Sits between the producers and the FIFO write side (wen/din/ready).

---
 rtl/fifo_write_arbiter.sv | 178 +++++++++++++++++
 tb/tb_fifo_write_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin share of one parallel-write FIFO port among NUM_REQ producers, in fixed bursts of BURST_LEN beats.
// Latency: 1 cycle arbitration (IDLE) before the first beat, plus a mandatory 1-cycle IDLE bubble after every burst.
// Backpressure: fifo_ready is passed straight to the owner's req_ready; a FIFO stall or a producer gap holds the burst.
// Optional: define ARB_IDLE_TIMEOUT_EN to abort a burst after TIMEOUT consecutive producer-gap cycles.
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int PAR_WRITE  = 2,
  parameter int BURST_LEN  = 4,
  parameter int TIMEOUT    = 8
) (
  input  logic                                          clk,
  input  logic                                          rstn,
  input  logic                                          clear,
  input  logic [NUM_REQ-1:0]                            req_valid,
  input  logic [NUM_REQ*PAR_WRITE*DATA_WIDTH-1:0]       req_data,
  output logic [NUM_REQ-1:0]                            req_ready,
  input  logic                                          fifo_ready,
  output logic                                          fifo_wen,
  output logic [PAR_WRITE*DATA_WIDTH-1:0]               fifo_din,
  output logic [$clog2(NUM_REQ)-1:0]                    grant_id,
  output logic                                          busy
);

  localparam int BW = PAR_WRITE * DATA_WIDTH;
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  // Reject configurations the arbiter cannot support.
  if (NUM_REQ < 2 || BURST_LEN < 1 || TIMEOUT < 1) begin : g_bad_param
    $error("fifo_write_arbiter: illegal parameter combination");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [CW-1:0] beat_cnt;

  logic [IW-1:0] pick;
  logic          pick_found;
  logic          owner_vld;
  logic          xfer;
  logic          last_beat;
  logic [IW-1:0] next_ptr;
  int            idx;

  // Round-robin pick: first requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    pick       = rr_ptr;
    pick_found = 1'b0;
    idx        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!pick_found && req_valid[idx]) begin
        pick       = IW'(idx);
        pick_found = 1'b1;
      end
    end
  end

  // Owner-side handshake terms and the pointer that follows the current owner.
  always_comb begin
    owner_vld = req_valid[grant_id];
    xfer      = (state == BURST) && owner_vld && fifo_ready;
    last_beat = (beat_cnt == CW'(BURST_LEN - 1));
    next_ptr  = (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
  end

  // Write-side muxing: only the owner sees fifo_ready, and only during a burst.
  always_comb begin
    req_ready = '0;
    fifo_wen  = 1'b0;
    fifo_din  = '0;
    busy      = (state == BURST);
    if (state == BURST) begin
      fifo_din            = req_data[int'(grant_id)*BW +: BW];
      req_ready[grant_id] = fifo_ready;
      fifo_wen            = owner_vld & fifo_ready;
    end
  end

`ifdef ARB_IDLE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_cnt;

  // Arbitration FSM with producer-gap timeout: a silent owner loses the grant after TIMEOUT cycles.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      grant_id <= '0;
      idle_cnt <= '0;
    end else if (clear) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      grant_id <= '0;
      idle_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_id <= pick;
            beat_cnt <= '0;
            idle_cnt <= '0;
            state    <= BURST;
          end
        end
        BURST: begin
          if (owner_vld) begin
            idle_cnt <= '0;
          end else if (idle_cnt == TW'(TIMEOUT - 1)) begin
            idle_cnt <= '0;
            state    <= IDLE;
            rr_ptr   <= next_ptr;
            beat_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
          if (xfer) begin
            if (last_beat) begin
              state    <= IDLE;
              rr_ptr   <= next_ptr;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  // Arbitration FSM: grant on request, count beats, release after BURST_LEN transfers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      grant_id <= '0;
    end else if (clear) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      grant_id <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_id <= pick;
            beat_cnt <= '0;
            state    <= BURST;
          end
        end
        BURST: begin
          if (xfer) begin
            if (last_beat) begin
              state    <= IDLE;
              rr_ptr   <= next_ptr;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Testbench for fifo_write_arbiter: directed test-plan scenarios followed by randomized traffic.
// Expected outputs come from a transaction-level model (owner / beats / pointer) and are queued per cycle.
// A negedge monitor pops each expectation and compares it with the DUT outputs.
module tb_fifo_write_arbiter;

  localparam int NR = 4;
  localparam int DW = 16;
  localparam int PW = 2;
  localparam int BW = PW * DW;
  localparam int BL = 4;
  localparam int TO = 8;

  logic              clk;
  logic              rstn;
  logic              clear;
  logic [NR-1:0]     req_valid;
  logic [NR*BW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic              fifo_ready;
  logic              fifo_wen;
  logic [BW-1:0]     fifo_din;
  logic [1:0]        grant_id;
  logic              busy;

  fifo_write_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .PAR_WRITE(PW), .BURST_LEN(BL), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rstn(rstn), .clear(clear),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .fifo_ready(fifo_ready), .fifo_wen(fifo_wen), .fifo_din(fifo_din),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          wen;
    logic [BW-1:0] din;
    logic [NR-1:0] rdy;
    logic          busy;
    logic [1:0]    gid;
  } exp_t;

  exp_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;

  // Producer payloads: each producer's word advances only when its beat is accepted,
  // so any lost or duplicated beat shows up as a data miscompare.
  logic [BW-1:0] pdata [NR];

  // Reference model: who owns the port (-1 = nobody), beats written, next search start.
  int m_owner, m_beats, m_ptr, m_gid, m_gap;

  function automatic void model_reset();
    m_owner = -1; m_beats = 0; m_ptr = 0; m_gid = 0; m_gap = 0;
  endfunction

  function automatic void end_burst();
    m_ptr   = (m_owner + 1) % NR;
    m_owner = -1;
    m_beats = 0;
    m_gap   = 0;
  endfunction

  task automatic step(input logic [NR-1:0] v, input logic fr, input logic clr, input logic rn);
    exp_t e;
    @(posedge clk);
    #1;
    req_valid  = v;
    fifo_ready = fr;
    clear      = clr;
    rstn       = rn;
    for (int i = 0; i < NR; i++) req_data[i*BW +: BW] = pdata[i];
    if (!rn) model_reset();
    e     = '0;
    e.gid = 2'(m_gid);
    if (m_owner >= 0) begin
      e.busy         = 1'b1;
      e.rdy[m_owner] = fr;
      e.wen          = v[m_owner] & fr;
      e.din          = pdata[m_owner];
    end
    exp_q.push_back(e);
    // Next-cycle model state.
    if (e.wen) pdata[m_owner] = pdata[m_owner] + 1;
    if (!rn || clr) begin
      model_reset();
    end else if (m_owner < 0) begin
      for (int k = 0; k < NR; k++) begin
        if (m_owner < 0 && v[(m_ptr + k) % NR]) begin
          m_owner = (m_ptr + k) % NR;
          m_gid   = m_owner;
          m_beats = 0;
          m_gap   = 0;
        end
      end
    end else if (e.wen) begin
      m_gap   = 0;
      m_beats = m_beats + 1;
      if (m_beats == BL) end_burst();
    end else if (v[m_owner]) begin
      m_gap = 0;
    end else begin
`ifdef ARB_IDLE_TIMEOUT_EN
      m_gap = m_gap + 1;
      if (m_gap == TO) end_burst();
`endif
    end
  endtask

  // Monitor: compare every queued expectation against the DUT half a cycle later.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (fifo_wen !== e.wen || fifo_din !== e.din || req_ready !== e.rdy ||
            busy !== e.busy || grant_id !== e.gid) begin
          miscompares++;
          $display("FAIL vec%0d t=%0t: got wen=%b din=%h rdy=%b busy=%b gid=%0d, want wen=%b din=%h rdy=%b busy=%b gid=%0d",
                   vectors, $time, fifo_wen, fifo_din, req_ready, busy, grant_id,
                   e.wen, e.din, e.rdy, e.busy, e.gid);
        end
        if ($countones(req_ready) > 1) begin
          miscompares++;
          $display("FAIL onehot t=%0t: req_ready=%b, want at most one bit set", $time, req_ready);
        end
      end
    end
  end

  initial begin
    clk        = 1'b0;
    rstn       = 1'b0;
    clear      = 1'b0;
    req_valid  = '0;
    fifo_ready = 1'b0;
    req_data   = '0;
    model_reset();
    for (int i = 0; i < NR; i++) pdata[i] = $urandom;

    // Reset state.
    step(4'b0000, 1'b0, 1'b0, 1'b0);
    step(4'b0000, 1'b1, 1'b0, 1'b0);

    // Lone requester 2: arbitrate, four beats A0..A3, then the bubble.
    pdata[2] = 32'h0000_00A0;
    for (int c = 0; c < 5; c++) step(4'b0100, 1'b1, 1'b0, 1'b1);
    step(4'b0000, 1'b1, 1'b0, 1'b1);

    // Pointer now at 3: requesters 3 and 0, 3 first then wrap to 0.
    for (int c = 0; c < 12; c++) step(4'b1001, 1'b1, 1'b0, 1'b1);
    step(4'b0000, 1'b1, 1'b1, 1'b1);

    // Everyone requesting: 0,1,2,3,0 with a bubble between bursts.
    for (int c = 0; c < 26; c++) step(4'b1111, 1'b1, 1'b0, 1'b1);
    step(4'b0000, 1'b1, 1'b1, 1'b1);

    // FIFO stall for three cycles after beat 2 of a grant to producer 1.
    for (int c = 0; c < 3; c++) step(4'b0010, 1'b1, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) step(4'b0010, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) step(4'b0010, 1'b1, 1'b0, 1'b1);
    step(4'b0000, 1'b1, 1'b1, 1'b1);

    // Clear pulsed on beat 2 of a burst to producer 2.
    step(4'b0100, 1'b1, 1'b0, 1'b1);
    step(4'b0100, 1'b1, 1'b0, 1'b1);
    step(4'b0100, 1'b1, 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) step(4'b0100, 1'b1, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a burst.
    for (int c = 0; c < 3; c++) step(4'b1111, 1'b1, 1'b0, 1'b1);
    step(4'b1111, 1'b1, 1'b0, 1'b0);
    step(4'b1111, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) step(4'b1111, 1'b1, 1'b0, 1'b1);
    step(4'b0000, 1'b1, 1'b1, 1'b1);

    // Owner 1 goes silent after one beat while producer 2 waits.
    step(4'b0010, 1'b1, 1'b0, 1'b1);
    step(4'b0010, 1'b1, 1'b0, 1'b1);
    for (int c = 0; c < 120; c++) step(4'b0100, 1'b1, 1'b0, 1'b1);
    step(4'b0000, 1'b1, 1'b1, 1'b1);

    // Randomized traffic with occasional clear and reset.
    for (int c = 0; c < 1500; c++) begin
      step(NR'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 63) == 0),
           ($urandom_range(0, 199) != 0));
    end

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
